// File: rtl/ex_div_ctrl.sv
// Multi-cycle RV32M divide/remainder sequencer for the execute stage.
// Restoring divider, one quotient bit per cycle, with pipeline hold and flush.
module ex_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              hold_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_wr_en_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    state_t state_q, state_d;

    logic              sel_rem_q, sel_rem_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              start_ok;
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic              div_zero;
    logic              ovf;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] result_c;

    // Only func3[2]=1 encodes a divide; anything else is not ours to accept.
    assign start_ok  = start_i & op_i[2] & ~flush_i;
    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & dividend_i[DATA_W-1];
    assign b_neg     = is_signed & divisor_i[DATA_W-1];
    assign a_abs     = a_neg ? -dividend_i : dividend_i;
    assign b_abs     = b_neg ? -divisor_i : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign ovf       = is_signed & (dividend_i == MIN_NEG)
                     & (divisor_i == '1);

    // One extra bit keeps the partial remainder from wrapping on big divisors.
    assign shifted  = {rem_q, dvd_q[DATA_W-1]};
    assign diff     = shifted - {1'b0, dsr_q};

    assign quo_fix  = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
    assign result_c = sel_rem_q ? rem_fix : quo_fix;

    assign busy_o     = (state_q != S_IDLE);
    assign rd_wr_en_o = ready_o;
    assign result_o   = ready_o ? result_c : res_q;
    assign rd_addr_o  = ready_o ? rd_q : rd_out_q;

    always_comb begin
        state_d   = state_q;
        sel_rem_d = sel_rem_q;
        rd_d      = rd_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        rd_out_d  = rd_out_q;
        hold_o    = 1'b0;
        ready_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                hold_o = start_ok;
                if (start_ok) begin
                    sel_rem_d = op_i[1];
                    rd_d      = rd_addr_i;
                    dvd_d     = a_abs;
                    dsr_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    state_d   = S_CALC;
                    // Architectural corner results bypass the iteration.
                    if (div_zero) begin
                        dvd_d     = '1;
                        rem_d     = dividend_i;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                    end else if (ovf) begin
                        dvd_d     = MIN_NEG;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_CALC: begin
                hold_o = ~flush_i;
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ready_o = ~flush_i;
                if (!flush_i) begin
                    res_d    = result_c;
                    rd_out_d = rd_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_rem_q <= 1'b0;
            rd_q      <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_rem_q <= sel_rem_d;
            rd_q      <= rd_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            rd_out_q  <= rd_out_d;
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: results, latency, hold, flush and reset.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        hold_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wr_en_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    ex_div_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .hold_o     (hold_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o),
        .rd_wr_en_o (rd_wr_en_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat,
                          input string tag);
        int lat;
        int hc;
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        #1;
        chk({tag, ":hold_start"}, 32'(hold_o), 32'd1);
        hc = 1;
        tick();
        lat = 1;
        start_i = 1'b0;
        #1;
        while (!ready_o && lat < 40) begin
            if (hold_o) hc++;
            tick();
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":hold_cycles"}, 32'(hc), 32'(exp_lat));
        chk({tag, ":result"}, result_o, exp);
        chk({tag, ":rd_addr"}, 32'(rd_addr_o), 32'(rd));
        chk({tag, ":wr_en"}, 32'(rd_wr_en_o), 32'd1);
        chk({tag, ":hold_done"}, 32'(hold_o), 32'd0);
        tick();
        chk({tag, ":idle_busy"}, 32'(busy_o), 32'd0);
        chk({tag, ":idle_ready"}, 32'(ready_o), 32'd0);
        chk({tag, ":held_result"}, result_o, exp);
    endtask

    initial begin
        int pulses;
        int r1;
        int r2;
        logic b34;
        logic h34;

        rst_n      = 1'b0;
        start_i    = 1'b0;
        op_i       = DIVU;
        dividend_i = '0;
        divisor_i  = '0;
        rd_addr_i  = '0;
        flush_i    = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_hold", 32'(hold_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", 32'(rd_addr_o), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, "divu_100_7");
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33, "div_7_m2");
        run_op(REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33, "rem_7_m2");
        run_op(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd10, 32'd1, 33, "divu_big");
        run_op(REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd11, 32'd1, 33, "remu_big");
        run_op(DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1, "remu_by0");
        run_op(DIV, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, "div_by0");
        run_op(REM, 32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9, 1, "rem_by0");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, "rem_ovf");

        // Flush at the tenth CALC cycle.
        start_i    = 1'b1;
        op_i       = DIV;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        rd_addr_i  = 5'd3;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        chk("flush_pre_busy", 32'(busy_o), 32'd1);
        chk("flush_pre_hold", 32'(hold_o), 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_hold", 32'(hold_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_busy", 32'(busy_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) pulses++;
            tick();
        end
        chk("flush_no_ready", 32'(pulses), 32'd0);
        run_op(DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33, "divu_9_3");

        // Start together with flush in IDLE is dropped.
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("drop_hold", 32'(hold_o), 32'd0);
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("drop_busy", 32'(busy_o), 32'd0);

        // start_i held high: one pulse per accepted start, restart after DONE.
        start_i    = 1'b1;
        op_i       = DIVU;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        rd_addr_i  = 5'd21;
        pulses = 0;
        r1 = 0;
        r2 = 0;
        b34 = 1'b1;
        h34 = 1'b0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (ready_o) begin
                pulses++;
                if (r1 == 0) r1 = t;
                else if (r2 == 0) r2 = t;
            end
            if (t == 34) begin
                b34 = busy_o;
                h34 = hold_o;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd2);
        chk("held_first", 32'(r1), 32'd33);
        chk("held_second", 32'(r2), 32'd67);
        chk("held_gap_busy", 32'(b34), 32'd0);
        chk("held_gap_hold", 32'(h34), 32'd1);
        start_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();

        // Reset in the middle of CALC.
        run_op(DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, "divu_pre_rst");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_hold", 32'(hold_o), 32'd0);
        chk("mrst_ready", 32'(ready_o), 32'd0);
        chk("mrst_result", result_o, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
